// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, tick divisors and rx state encoding.
// Imported by the tick generator and the receiver.
package uart_pkg;

  localparam logic [1:0] BAUD_9600  = 2'b00;
  localparam logic [1:0] BAUD_19200 = 2'b01;
  localparam logic [1:0] BAUD_38400 = 2'b10;
  localparam logic [1:0] BAUD_57600 = 2'b11;

  localparam int DIV_9600  = 326;
  localparam int DIV_19200 = 163;
  localparam int DIV_38400 = 81;
  localparam int DIV_57600 = 54;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int SAMP_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic int div_of(input logic [1:0] code);
    unique case (code)
      BAUD_9600:  return DIV_9600;
      BAUD_19200: return DIV_19200;
      BAUD_38400: return DIV_38400;
      default:    return DIV_57600;
    endcase
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Baud tick divider with synchronous restart; SCALE widens the divisor
// so the same block can pace a 1x transmitter.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [1:0] baud_sel,
  output logic       tick
);

  localparam int W = $clog2(DIV_9600 * SCALE + 1);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  assign last = W'(div_of(baud_sel) * SCALE - 1);
  assign tick = !restart && (cnt == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, holding
// register with valid/ready hand-off, framing and overrun pulses.
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  logic                 rx_m;
  logic                 rx_s;
  logic                 rx_d;
  logic [1:0]           baud_q;
  rx_state_e            state;
  logic [SAMP_W-1:0]    samp_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 fall;
  logic                 restart;
  logic                 bit_end;
  logic                 mid_start;

  assign fall      = rx_d && !rx_s;
  assign restart   = (state == IDLE) && fall;
  assign bit_end   = samp_cnt == SAMP_W'(OVERSAMPLE - 1);
  assign mid_start = samp_cnt == SAMP_W'(OVERSAMPLE / 2 - 1);

  uart_tick_gen #(
    .SCALE(1)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .baud_sel(baud_q),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      baud_q      <= BAUD_9600;
      samp_cnt    <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (fall) begin
            baud_q   <= baud_sel;
            samp_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
            if (mid_start) begin
              if (!rx_s) begin
                samp_cnt <= '0;
                bit_idx  <= '0;
                state    <= DATA;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        DATA: begin
          if (tick) begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
            if (bit_end) begin
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_idx <= bit_idx + BIT_W'(1);
              if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
            if (bit_end) begin
              state <= IDLE;
              if (rx_s) begin
                // newest byte wins; a same-cycle accept is not an overrun
                rx_data     <= shreg;
                rx_valid    <= 1'b1;
                overrun_err <= rx_valid && !rx_ready;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
